// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving one external full-adder stage, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // SHIFT | one bit pair through the full adder per clock
    // DONE  | one-cycle result pulse; start here chains the next add
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             accept, last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Adder inputs come straight from registers and are forced low outside SHIFT.
    assign fa_a    = busy & a_sr[0];
    assign fa_b    = busy & b_sr[0];
    assign fa_c    = busy & carry_q;
    assign sum_nxt = {fa_sum, sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry_q <= cin;
            cnt     <= '0;
        end else if (busy) begin
            sum_sr  <= sum_nxt;
            carry_q <= fa_carry;
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_out <= sum_nxt;
                cout    <= fa_carry;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB is still in carry_q on the final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   ovf <= 1'b0;
        else if (busy && last_bit) ovf <= carry_q ^ fa_carry;
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural full adder beside it.
// Define SERIAL_ADD_OVF_EN for both files to cover the overflow output.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic         cin = 1'b0;
    logic         fa_a, fa_b, fa_c, fa_sum, fa_carry;
    logic         busy, done, cout;
    logic [W-1:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_sum(fa_sum), .fa_carry(fa_carry),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    // External full adder
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: operands, bit index in flight, remaining busy cycles.
    logic [W-1:0] m_a, m_b, m_sum;
    logic         m_cin, m_cout, m_ovf, m_done;
    int           m_left, m_step;
    logic [W:0]   m_full;

    assign m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};

    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int k);
        logic [31:0] mask, s;
        mask = (32'd1 << k) - 32'd1;
        s    = (32'(a) & mask) + (32'(b) & mask) + 32'(c);
        return s[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= '0; m_b <= '0; m_cin <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_done <= 1'b0;
            m_left <= 0; m_step <= 0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum  <= m_full[W-1:0];
                m_cout <= m_full[W];
                m_ovf  <= (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
            end
            if (m_left > 0) begin
                m_left <= m_left - 1;
                m_step <= m_step + 1;
            end else if (start) begin
                m_left <= W;
                m_step <= 0;
                m_a    <= a_in;
                m_b    <= b_in;
                m_cin  <= cin;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("sum_out", 32'(sum_out), 32'(m_sum));
            check("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(ovf), 32'(m_ovf));
`endif
            if (m_left > 0) begin
                check("fa_a", 32'(fa_a), 32'(m_a[m_step]));
                check("fa_b", 32'(fa_b), 32'(m_b[m_step]));
                check("fa_c", 32'(fa_c), 32'(carry_into(m_a, m_b, m_cin, m_step)));
            end else begin
                check("fa_idle", 32'({fa_a, fa_b, fa_c}), 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1; a_in = a; b_in = b; cin = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, output int cyc, output int nbusy,
                             output logic [W-1:0] seq);
        cyc = cyc0; nbusy = 0; seq = '0;
        while (!done && cyc < 40) begin
            if (busy && nbusy < W) begin
                seq[nbusy] = fa_a;
                nbusy++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    int cyc, nbusy;
    logic [W-1:0] seq;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_op(8'h35, 8'h4A, 1'b0);
        wait_done(1, cyc, nbusy, seq);
        check("t1_latency", 32'(cyc), 32'd9);
        check("t1_busy_cycles", 32'(nbusy), 32'd8);
        check("t1_fa_a_seq", 32'(seq), 32'h35);
        check("t1_sum", 32'(sum_out), 32'h7F);
        check("t1_cout", 32'(cout), 32'd0);

        @(negedge clk);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(1, cyc, nbusy, seq);
        check("t2_sum", 32'(sum_out), 32'h00);
        check("t2_cout", 32'(cout), 32'd1);
        start_op(8'hFF, 8'hFF, 1'b1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(1, cyc, nbusy, seq);
        check("b2b_latency", 32'(cyc), 32'd9);
        check("b2b_sum", 32'(sum_out), 32'hFF);
        check("b2b_cout", 32'(cout), 32'd1);

        @(negedge clk);
        start_op(8'h01, 8'h02, 1'b0);
        start = 1'b1; a_in = 8'h10; b_in = 8'h10;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, cyc, nbusy, seq);
        check("ign_latency", 32'(cyc), 32'd9);
        check("ign_sum", 32'(sum_out), 32'h03);
        @(negedge clk);
        check("ign_single_done", 32'({busy, done}), 32'd0);

        start_op(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(1, cyc, nbusy, seq);
        check("post_rst_sum", 32'(sum_out), 32'h02);

`ifdef SERIAL_ADD_OVF_EN
        @(negedge clk);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(1, cyc, nbusy, seq);
        check("ovf1_sum", 32'(sum_out), 32'h80);
        check("ovf1_cout", 32'(cout), 32'd0);
        check("ovf1_ovf", 32'(ovf), 32'd1);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(1, cyc, nbusy, seq);
        check("ovf2_ovf", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            cin   = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
